// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
//   Two-primary, one-secondary Wishbone arbiter. The bus is owned by one
//   primary for a whole cyc cycle; ownership is chosen round-robin and held
//   in a registered grant state. Request signals of the owner are forwarded
//   combinationally to the secondary; ack is returned only to the owner and
//   read data is broadcast to both primaries.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   p0_* / p1_*           : primary request (cyc, stb, we, addr, sel, dat_o)
//                           and response (dat_i, ack)
//   s_*                   : forwarded request to the secondary, its dat_i/ack
//   grant                 : one-hot current owner (01 = p0, 10 = p1, 00 = idle)
module wishbone_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int ADDR_SIZE = 32,
  localparam int SEL_SIZE = DATA_SIZE / BYTE_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 p0_cyc,
  input  logic                 p0_stb,
  input  logic                 p0_we,
  input  logic [ADDR_SIZE-1:0] p0_addr,
  input  logic [SEL_SIZE-1:0]  p0_sel,
  input  logic [DATA_SIZE-1:0] p0_dat_o,
  output logic [DATA_SIZE-1:0] p0_dat_i,
  output logic                 p0_ack,
  input  logic                 p1_cyc,
  input  logic                 p1_stb,
  input  logic                 p1_we,
  input  logic [ADDR_SIZE-1:0] p1_addr,
  input  logic [SEL_SIZE-1:0]  p1_sel,
  input  logic [DATA_SIZE-1:0] p1_dat_o,
  output logic [DATA_SIZE-1:0] p1_dat_i,
  output logic                 p1_ack,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [ADDR_SIZE-1:0] s_addr,
  output logic [SEL_SIZE-1:0]  s_sel,
  output logic [DATA_SIZE-1:0] s_dat_o,
  input  logic [DATA_SIZE-1:0] s_dat_i,
  input  logic                 s_ack,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // 0 = p0 granted most recently, 1 = p1

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;      // p0 wins the first tie
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (p0_cyc && p1_cyc) state_d = last_q ? GRANT0 : GRANT1;
        else if (p0_cyc)      state_d = GRANT0;
        else if (p1_cyc)      state_d = GRANT1;
      end
      // Owner keeps the bus for its whole cyc; on release hand straight over
      // to a waiting primary so there is no idle bubble between owners.
      GRANT0: if (!p0_cyc) state_d = p1_cyc ? GRANT1 : IDLE;
      GRANT1: if (!p1_cyc) state_d = p0_cyc ? GRANT0 : IDLE;
      default: state_d = IDLE;
    endcase
    // last tracks whichever primary the next state grants
    case (state_d)
      GRANT0:  last_d = 1'b0;
      GRANT1:  last_d = 1'b1;
      default: last_d = last_q;
    endcase
  end

  assign grant = {state_q == GRANT1, state_q == GRANT0};

  // Forwarding uses the current owner's live cyc, so s_cyc drops in the same
  // cycle the owner releases even though the state moves only at the edge.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_sel   = '0;
    s_dat_o = '0;
    case (state_q)
      GRANT0: begin
        s_cyc   = p0_cyc;
        s_stb   = p0_stb;
        s_we    = p0_we;
        s_addr  = p0_addr;
        s_sel   = p0_sel;
        s_dat_o = p0_dat_o;
      end
      GRANT1: begin
        s_cyc   = p1_cyc;
        s_stb   = p1_stb;
        s_we    = p1_we;
        s_addr  = p1_addr;
        s_sel   = p1_sel;
        s_dat_o = p1_dat_o;
      end
      default: ;
    endcase
  end

  // An ack with no owner (idle) reaches nobody.
  assign p0_ack   = s_ack & grant[0];
  assign p1_ack   = s_ack & grant[1];
  assign p0_dat_i = s_dat_i;
  assign p1_dat_i = s_dat_i;

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Two-primary, one-secondary Wishbone bus arbiter placed between the core's instruction/data fetch primaries and the memory-side Wishbone secondary. It grants the shared bus to one primary for the whole `cyc` cycle, using round-robin priority with a registered grant. It forwards the granted primary's signals to the secondary and routes `ack` back only to the owner. Signal semantics match the team's `wishbone_if`: `rd_en = cyc & stb & ~we`, `wr_en = cyc & stb & we`.

## Interface
- `DATA_SIZE`, default 32: data bus width.
- `BYTE_SIZE`, default 8: byte width; `sel` is `DATA_SIZE/BYTE_SIZE` bits.
- `ADDR_SIZE`, default 32: address width.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `p0_cyc`, `p0_stb`, `p0_we`  in  1 each  primary 0 bus cycle, strobe, write enable.
- `p0_addr`  in  ADDR_SIZE  primary 0 address.
- `p0_sel`  in  DATA_SIZE/BYTE_SIZE  primary 0 byte select.
- `p0_dat_o`  in  DATA_SIZE  primary 0 write data.
- `p0_dat_i`  out  DATA_SIZE  read data to primary 0.
- `p0_ack`  out  1  acknowledge to primary 0.
- `p1_*`: the same eight ports for primary 1.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to the secondary.
- `s_addr`  out  ADDR_SIZE; `s_sel`  out  DATA_SIZE/BYTE_SIZE; `s_dat_o`  out  DATA_SIZE  to the secondary.
- `s_dat_i`  in  DATA_SIZE  read data from the secondary.
- `s_ack`  in  1  acknowledge from the secondary.
- `grant`  out  2  one-hot current owner (`01` = primary 0, `10` = primary 1, `00` = idle); for debug and verification.

## Operation
- States: IDLE, GRANT0, GRANT1. Register `last` records the most recently granted primary.
- IDLE:
  - Only `p0_cyc` asserted: go to GRANT0.
  - Only `p1_cyc` asserted: go to GRANT1.
  - Both asserted: grant the primary that is not `last`.
  - Neither asserted: stay in IDLE.
- GRANTx: hold while `px_cyc` = 1. Requests from the other primary are ignored.
- GRANTx with `px_cyc` = 0:
  - Other primary's `cyc` = 1: go directly to the other grant state. No IDLE bubble.
  - Otherwise: go to IDLE.
- Entering GRANTx sets `last` = x.
- Forwarding is combinational from the granted primary:
  - `s_cyc/stb/we/addr/sel/dat_o` = `px_*`.
  - In IDLE these outputs are all 0.
- `px_ack = s_ack & grant[x]`. The non-owner's `ack` is always 0.
- `p0_dat_i = p1_dat_i = s_dat_i` (broadcast). Primaries qualify read data with their own `ack`.
- `s_cyc` equals the owner's `cyc`. When the owner drops `cyc`, `s_cyc` falls in the same cycle, even though the state changes only at the next edge.
- The arbiter never splits a cycle. Back-to-back `stb` pulses under one `cyc` (burst/RMW) stay with the same owner.

## Timing
- Reset values (cycle after the reset edge):
  - State IDLE, `last` = 1 (primary 0 wins the first tie).
  - `grant` = `00`.
  - All `s_*` outputs 0; `p0_ack` = `p1_ack` = 0.
- Arbitration latency is 1 cycle. A primary raising `cyc` in cycle N from IDLE sees `s_cyc` = 1 and `grant` set in cycle N+1.
- Handoff latency is 1 cycle. The owner drops `cyc` in cycle N, and the other primary is granted in cycle N+1.
- `ack`, `dat_i` and the forwarded request signals have 0-cycle (combinational) latency. The secondary's own wait states pass through unchanged.
- Simultaneous owner release and rising request from the same primary: that primary re-enters arbitration. If the other primary is also requesting, the other wins (round-robin).
- An `s_ack` arriving in IDLE is dropped and is not routed to either primary.
- Reset mid-transaction: the next edge returns to IDLE, all `s_*` outputs go to 0, and any pending `ack` is lost. Primaries must reissue.

## Test plan
- Reset then idle: hold `reset` 2 cycles with both `cyc` = 0 → `grant` = `00`, `s_cyc` = 0, both `ack` = 0.
- Single read: `p0` cyc/stb = 1, we = 0, addr = 0x100; secondary acks on cycle 3 with `s_dat_i` = 0xDEADBEEF → `s_addr` = 0x100 from cycle 1, `p0_ack` = 1 only in the ack cycle, `p0_dat_i` = 0xDEADBEEF, `p1_ack` = 0.
- Tie after reset: both `cyc` rise in the same cycle → GRANT0 first. When `p0` drops `cyc`, GRANT1 follows the next cycle with no IDLE.
- Round-robin fairness: both primaries continuously re-request after each release → grants alternate 0, 1, 0, 1 over 8 transactions, and neither primary is granted twice in a row.
- Locked burst: `p1` holds `cyc` over 3 stb/ack writes (addr 0x10, 0x14, 0x18) while `p0_cyc` = 1 → `s_addr` sequence is 0x10, 0x14, 0x18 from `p1`, and `p0` is granted only after `p1_cyc` falls.
- Reset mid-cycle: assert `reset` while in GRANT1 with `stb` = 1 and `s_ack` = 1 → next cycle `grant` = `00`, `s_cyc` = 0, `p1_ack` = 0.
